// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Optional feature macro: RR_ARBITER_TIMEOUT_EN (grant hold timeout).
package rr_arbiter_pkg;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  // Priority mask after reset: "last owner" was bit 7, so bit 0 wins first.
  localparam logic [N-1:0] LAST_RST = 8'b1000_0000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Position of the set bit in a one-hot vector (highest set bit wins).
  function automatic logic [2:0] onehot_pos(input logic [N-1:0] v);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        pos = 3'(i);
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit searching upward
// (wrapping) from the bit after the previous owner. Zero when req is zero.
module rr_pick
  import rr_arbiter_pkg::*;
(
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] pick
);

  logic [3:0]   shamt;
  logic [N-1:0] rot;
  logic [N-1:0] low;

  // Rotate req so the bit after `last` lands at position 0, isolate the
  // lowest set bit, then rotate that one-hot back into place.
  always_comb begin
    shamt = {1'b0, onehot_pos(last)} + 4'd1;
    rot   = N'({req, req} >> shamt);
    low   = rot & (~rot + 8'd1);
    pick  = N'(({low, low} << shamt) >> N);
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant.
// Optional feature macro: RR_ARBITER_TIMEOUT_EN -- when defined, a grant
// held for HOLD_MAX cycles is revoked and timeout pulses for one cycle.
// The owner-release input is named owner_release because "release" is a
// reserved word in SystemVerilog.
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         owner_release,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout
);

  import rr_arbiter_pkg::*;

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] grant_nxt;
  logic [N-1:0] last;
  logic [N-1:0] last_nxt;
  logic [N-1:0] pick;
  logic         owner_gone;
  logic         hold_hit;
  logic         exit_grant;

  rr_pick u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  // Owner withdrew its request or asked to release the grant.
  always_comb begin
    owner_gone = ((req & grant) == {N{1'b0}});
    exit_grant = (state == GRANT) && (owner_release || owner_gone || hold_hit);
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic             timeout_reg;
  logic             timeout_nxt;

  // Hold counter: 1 on the first grant cycle, saturating, cleared on exit.
  always_comb begin
    hold_hit     = (state == GRANT) && (hold_cnt == HOLD_LIMIT);
    hold_cnt_nxt = hold_cnt;
    if (exit_grant) begin
      hold_cnt_nxt = 4'd0;
    end else if (state == IDLE) begin
      hold_cnt_nxt = (pick != {N{1'b0}}) ? 4'd1 : 4'd0;
    end else if (hold_cnt != 4'hF) begin
      hold_cnt_nxt = hold_cnt + 4'd1;
    end else begin
      hold_cnt_nxt = hold_cnt;
    end
    // A voluntary exit in the same cycle takes precedence over revocation.
    timeout_nxt = exit_grant && hold_hit && !owner_release && !owner_gone;
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= 4'd0;
      timeout_reg <= 1'b0;
    end else begin
      hold_cnt    <= hold_cnt_nxt;
      timeout_reg <= timeout_nxt;
    end
  end

  assign timeout = timeout_reg;
`else
  // Without the timeout feature grants are held until release or withdraw.
  always_comb begin
    hold_hit = 1'b0;
  end

  assign timeout = 1'b0;
`endif

  // Next-state, next-grant and priority-mask update.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick != {N{1'b0}}) begin
          grant_nxt = pick;
          state_nxt = GRANT;
        end else begin
          grant_nxt = {N{1'b0}};
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (exit_grant) begin
          grant_nxt = {N{1'b0}};
          last_nxt  = grant;
          state_nxt = IDLE;
        end else begin
          grant_nxt = grant;
          state_nxt = GRANT;
        end
      end
      default: begin
        grant_nxt = {N{1'b0}};
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and priority-mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= {N{1'b0}};
      last  <= LAST_RST;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural owner/priority model.
module tb_rr_arbiter_8;

  localparam int HOLD_MAX = 15;
`ifdef RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       owner_release = 1'b0;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_8 #(.N(8), .HOLD_MAX(HOLD_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .owner_release (owner_release),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner index (-1 = none), index of previous owner,
  // cycles held so far, and pending timeout pulse.
  typedef struct packed {
    int owner;
    int last;
    int hold;
    bit to;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s, input logic [7:0] r, input logic rl);
    mstate_t n;
    bit found;
    bit wd;
    bit hit;
    n = s;
    n.to = 1'b0;
    if (s.owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && r[(s.last + k) % 8]) begin
          found   = 1'b1;
          n.owner = (s.last + k) % 8;
          n.hold  = 1;
        end
      end
    end else begin
      wd  = !r[s.owner];
      hit = TO_EN && (s.hold >= HOLD_MAX);
      if (rl || wd || hit) begin
        n.to    = hit && !rl && !wd;
        n.last  = s.owner;
        n.owner = -1;
        n.hold  = 0;
      end else begin
        n.hold = (s.hold < 15) ? s.hold + 1 : 15;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '{owner: -1, last: 7, hold: 0, to: 1'b0};
    end else begin
      m <= model_next(m, req, owner_release);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [7:0] eg;
    eg = (m.owner < 0) ? 8'h00 : (8'h01 << m.owner);
    check("model_grant", grant, eg);
    check("model_valid", {7'd0, grant_valid}, {7'd0, (m.owner >= 0)});
    check("model_timeout", {7'd0, timeout}, {7'd0, m.to});
  end

  task automatic cyc(input logic [7:0] r, input logic rl);
    req = r;
    owner_release = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00;
    owner_release = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] rq;

  initial begin
    // Reset state.
    @(posedge clk);
    #1;
    check("rst_grant", grant, 8'h00);
    check("rst_valid", {7'd0, grant_valid}, 8'h00);
    check("rst_timeout", {7'd0, timeout}, 8'h00);
    do_reset();

    // Basic grant, release, one idle gap, next requester.
    cyc(8'h05, 1'b0); check("t1_first", grant, 8'h01);
    check("t1_valid", {7'd0, grant_valid}, 8'h01);
    cyc(8'h05, 1'b1); check("t1_release", grant, 8'h00);
    cyc(8'h05, 1'b0); check("t1_second", grant, 8'h04);
    cyc(8'h05, 1'b1); check("t1_release2", grant, 8'h00);

    // Full rotation with all requesting.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b0); check("t2_grant", grant, 8'h01 << (i % 8));
      cyc(8'hFF, 1'b1); check("t2_gap", grant, 8'h00);
    end

    // Owner withdraw moves priority past the owner.
    do_reset();
    cyc(8'h08, 1'b0); check("t3_grant", grant, 8'h08);
    cyc(8'h11, 1'b0); check("t3_withdraw", grant, 8'h00);
    cyc(8'h11, 1'b0); check("t3_next", grant, 8'h10);

    // Hold without release: timeout after 15 cycles, or held indefinitely.
    do_reset();
    cyc(8'h02, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc(8'h02, 1'b0); check("t4_hold", grant, 8'h02);
    end
    cyc(8'h02, 1'b0);
`ifdef RR_ARBITER_TIMEOUT_EN
    check("t4_to_grant", grant, 8'h00);
    check("t4_to_pulse", {7'd0, timeout}, 8'h01);
    cyc(8'h02, 1'b0);
    check("t4_to_end", {7'd0, timeout}, 8'h00);
    check("t4_regrant", grant, 8'h02);
`else
    check("t4_noto_grant", grant, 8'h02);
    for (int i = 0; i < 100; i++) begin
      cyc(8'h02, 1'b0);
    end
    check("t4_noto_long", grant, 8'h02);
    check("t4_noto_pulse", {7'd0, timeout}, 8'h00);
`endif

    // Release coincides with the timeout cycle.
    do_reset();
    cyc(8'h02, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc(8'h02, 1'b0);
    end
    cyc(8'h02, 1'b1);
    check("t5_grant", grant, 8'h00);
    check("t5_timeout", {7'd0, timeout}, 8'h00);

    // Asynchronous reset mid-grant restores priority to bit 0 upward.
    do_reset();
    cyc(8'h40, 1'b0); check("t6_grant", grant, 8'h40);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_grant", grant, 8'h00);
    check("t6_async_valid", {7'd0, grant_valid}, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(8'hC0, 1'b0); check("t6_after", grant, 8'h40);

    // Randomized traffic; requests mostly persist, bits toggle occasionally.
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) begin
          rq[b] = ~rq[b];
        end
      end
      cyc(rq, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that turns a request vector into a registered one-hot grant. It sits directly upstream of the team's 8-to-3 one-hot encoder, which converts the grant into a 3-bit owner index. Each grant is held until the owner releases it. Priority then rotates to the requester after the previous owner, so no requester starves.

## Interface
Parameters:
- N, 8, number of requesters; fixed at 8 to match the downstream encoder.
- HOLD_MAX, 15, maximum cycles a grant may be held (used only with the timeout feature).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request lines, level-sensitive; bit i = requester i.
- release  input  1  current owner finished; sampled only in GRANT.
- grant  output  N  registered grant, one-hot or all-zero; never more than one bit set.
- grant_valid  output  1  high exactly when grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values:
  - grant = 8'b00000000, grant_valid = 0, timeout = 0.
  - State IDLE.
  - Priority mask `last` = 8'b10000000, so requester 0 has highest priority first.
- State IDLE:
  - If req != 0, pick the first set req bit searching upward (wrapping) from the bit after `last`.
  - Load grant with that one-hot and go to GRANT.
  - If req == 0, stay in IDLE with grant = 0.
- State GRANT: grant held constant. Exit to IDLE when any of the following holds:
  - release == 1;
  - req bit of the current owner == 0 (owner withdrew);
  - hold counter reaches HOLD_MAX (timeout feature only).
- On exit:
  - grant cleared to 0 and `last` loaded with the exiting grant.
  - The hold counter clears.
- Hold counter: 4 bits, counts cycles in GRANT starting at 1 on the first grant cycle, saturates.
- release while in IDLE is ignored.
- Requests arriving or changing during GRANT have no effect until the next IDLE cycle.

## Timing
- Grant latency: req sampled on edge k in IDLE produces grant from edge k onward (visible cycle k+1).
- Release: sampled high on edge k drops grant at edge k.
- Mandatory gap: at least one IDLE cycle with grant = 0 between consecutive grants. The earliest next grant appears at edge k+1.
- Simultaneous exit events:
  - release and owner-withdraw in the same cycle count as a single exit.
  - release and timeout in the same cycle count as a release; timeout stays 0.
- Reset mid-grant: grant and grant_valid go to 0 immediately (asynchronously), `last` returns to 8'b10000000.
- grant_valid is derived from the same register as grant, with zero skew.

## Configuration
- Macro: RR_ARBITER_TIMEOUT_EN.
- Defined:
  - Hold counter and HOLD_MAX check compiled in.
  - Reaching HOLD_MAX cycles in GRANT forces exit and pulses timeout high for the one cycle where grant drops.
- Undefined:
  - Counter removed; grants held indefinitely until release or withdraw.
  - timeout port tied to 0.
  - HOLD_MAX ignored.

## Structure
- Package rr_arbiter_pkg holds:
  - the state typedef (IDLE, GRANT);
  - the constant N = 8;
  - the hold-counter width constant;
  - the reset value of `last`.
- One combinational sub-module, rr_pick.
  - Inputs: req[7:0] and last[7:0].
  - Output: the one-hot pick using a double-width rotate-and-mask search.
  - Output is 0 when req == 0.
- The top level holds the FSM, the grant/last registers and the optional counter. No index encoding is done internally; that is the downstream stage's job.

## Test plan
- Reset, then req=8'b00000101 → grant=8'b00000001 one cycle later. Release → one zero cycle, then grant=8'b00000100.
- req=8'b11111111 held, release pulsed once per grant → grants cycle 0x01,0x02,0x04,…,0x80,0x01, each separated by exactly one all-zero cycle.
- Grant 0x08, then owner drops req[3] with release=0 → grant=0 next cycle; `last` updated so bit 4 has priority next.
- Timeout build, HOLD_MAX=15, req=8'b00000010, no release → grant held 15 cycles, then grant=0 with timeout=1 for one cycle. Non-timeout build → grant held for 100+ cycles.
- release and timeout coincide on cycle 15 → grant=0, timeout stays 0.
- rst asserted mid-grant (grant=0x40) between clock edges → grant=0 and grant_valid=0 immediately. After rst deasserts with req=8'b11000000 → grant=0x40, since priority is restored to bit 0 upward.
